// File: rtl/rot_pkg.sv
// Shared types, constants and helpers for the rotator command path.
package rot_pkg;

  localparam int unsigned ROT_WIDTH = 8;
  localparam int unsigned ROT_SHW   = $clog2(ROT_WIDTH);

  localparam logic ROT_LEFT  = 1'b1;
  localparam logic ROT_RIGHT = 1'b0;

  // Rotate command as seen by the rotator at the default data width.
  typedef struct packed {
    logic                 dir;
    logic [ROT_SHW-1:0]   shamt;
    logic [ROT_WIDTH-1:0] data;
  } rot_cmd_t;

  // Control bits of a command: direction plus shift amount.
  function automatic int unsigned cmd_bits(input int unsigned width);
    return 1 + $clog2(width);
  endfunction

endpackage

// File: rtl/rot_fifo_ptr.sv
// Pointer, occupancy and full/empty tracking for the command FIFO.
module rot_fifo_ptr
  import rot_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointers carry a wrap bit in the MSB; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Status decode from the registered pointers only.
  always_comb begin
    wr_addr = r_wr_ptr[AW-1:0];
    rd_addr = r_rd_ptr[AW-1:0];
    count   = r_count;
    empty   = (r_wr_ptr == r_rd_ptr);
    full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
              (r_wr_ptr[AW] != r_rd_ptr[AW]);
  end

endmodule

// File: rtl/rotator_cmd_fifo.sv
// First-word-fall-through FIFO of rotate commands feeding the rotator.
module rotator_cmd_fifo
  import rot_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned SHW   = $clog2(WIDTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_dir,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             rot_dir,
  output logic [SHW-1:0]   rot_shamt,
  output logic [WIDTH-1:0] rot_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CMD_W = cmd_bits(WIDTH) + WIDTH;

  typedef struct packed {
    logic             dir;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data;
  } cmd_t;

  cmd_t          r_mem [DEPTH];
  cmd_t          w_head;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Handshakes qualified by registered status only.
  always_comb begin
    w_push = in_valid & ~w_full;
    w_pop  = out_ready & ~w_empty;
  end

  rot_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (w_push),
    .pop     (w_pop),
    .wr_addr (w_wr_addr),
    .rd_addr (w_rd_addr),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Command storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[w_wr_addr] <= cmd_t'({in_dir, in_shamt, in_data});
    end
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    w_head    = r_mem[w_rd_addr];
    rot_dir   = 1'b0;
    rot_shamt = '0;
    rot_data  = '0;
    if (!w_empty) begin
      rot_dir   = w_head.dir;
      rot_shamt = w_head.shamt;
      rot_data  = w_head.data;
    end
    count     = w_count;
    full      = w_full;
    empty     = w_empty;
    in_ready  = ~w_full;
    out_valid = ~w_empty;
  end

  // Package-level command width must agree with the local layout at defaults.
  if (WIDTH == ROT_WIDTH) begin : g_width_check
    if ($bits(rot_cmd_t) != CMD_W) begin : g_bad
      $error("command layout width disagrees with rot_pkg");
    end
  end

endmodule

// File: tb/tb_rotator_cmd_fifo.sv
// Directed, table-driven check of the rotate command FIFO.
module tb_rotator_cmd_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic       in_dir;
  logic [2:0] in_shamt;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       rot_dir;
  logic [2:0] rot_shamt;
  logic [7:0] rot_data;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rotator_cmd_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dir    (in_dir),
    .in_shamt  (in_shamt),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rot_dir   (rot_dir),
    .rot_shamt (rot_shamt),
    .rot_data  (rot_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  typedef struct {
    logic       fl;
    logic       iv;
    logic       dir;
    logic [2:0] sh;
    logic [7:0] data;
    logic       ordy;
    logic [2:0] e_cnt;
    logic       e_val;
    logic       e_dir;
    logic [2:0] e_sh;
    logic [7:0] e_data;
    logic       e_full;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic fl, input logic iv, input logic dir, input logic [2:0] sh,
                     input logic [7:0] data, input logic ordy, input logic [2:0] e_cnt,
                     input logic e_val, input logic e_dir, input logic [2:0] e_sh,
                     input logic [7:0] e_data, input logic e_full);
    vec_t v;
    v.fl = fl; v.iv = iv; v.dir = dir; v.sh = sh; v.data = data; v.ordy = ordy;
    v.e_cnt = e_cnt; v.e_val = e_val; v.e_dir = e_dir; v.e_sh = e_sh;
    v.e_data = e_data; v.e_full = e_full;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic fl, input logic iv, input logic dir, input logic [2:0] sh,
                       input logic [7:0] data, input logic ordy);
    flush = fl; in_valid = iv; in_dir = dir; in_shamt = sh; in_data = data; out_ready = ordy;
  endtask

  task automatic check_all(input int idx, input logic [2:0] e_cnt, input logic e_val,
                           input logic e_dir, input logic [2:0] e_sh, input logic [7:0] e_data,
                           input logic e_full);
    chk("count",     idx, 32'(count),     32'(e_cnt));
    chk("out_valid", idx, 32'(out_valid), 32'(e_val));
    chk("empty",     idx, 32'(empty),     32'(e_cnt == 3'd0));
    chk("full",      idx, 32'(full),      32'(e_full));
    chk("in_ready",  idx, 32'(in_ready),  32'(!e_full));
    chk("rot_dir",   idx, 32'(rot_dir),   32'(e_dir));
    chk("rot_shamt", idx, 32'(rot_shamt), 32'(e_sh));
    chk("rot_data",  idx, 32'(rot_data),  32'(e_data));
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single push, then pop to empty.
    add(0,1,1,3'd2,8'hA5,0, 3'd1,1,1,3'd2,8'hA5,0);
    add(0,0,0,3'd0,8'h00,1, 3'd0,0,0,3'd0,8'h00,0);
    // Fill to full; head stays at the first command.
    add(0,1,1,3'd1,8'h01,0, 3'd1,1,1,3'd1,8'h01,0);
    add(0,1,0,3'd2,8'h02,0, 3'd2,1,1,3'd1,8'h01,0);
    add(0,1,1,3'd3,8'h03,0, 3'd3,1,1,3'd1,8'h01,0);
    add(0,1,0,3'd4,8'h04,0, 3'd4,1,1,3'd1,8'h01,1);
    // Push while full is dropped.
    add(0,1,1,3'd5,8'h05,0, 3'd4,1,1,3'd1,8'h01,1);
    // Push plus pop while full: only the pop happens.
    add(0,1,0,3'd6,8'h06,1, 3'd3,1,0,3'd2,8'h02,0);
    add(0,0,0,3'd0,8'h00,1, 3'd2,1,1,3'd3,8'h03,0);
    add(0,0,0,3'd0,8'h00,1, 3'd1,1,0,3'd4,8'h04,0);
    add(0,0,0,3'd0,8'h00,1, 3'd0,0,0,3'd0,8'h00,0);
    // Pop on empty is ignored.
    add(0,0,0,3'd0,8'h00,1, 3'd0,0,0,3'd0,8'h00,0);
    // Three entries, then flush beats push and pop.
    add(0,1,0,3'd1,8'h21,0, 3'd1,1,0,3'd1,8'h21,0);
    add(0,1,1,3'd2,8'h22,0, 3'd2,1,0,3'd1,8'h21,0);
    add(0,1,0,3'd3,8'h23,0, 3'd3,1,0,3'd1,8'h21,0);
    add(1,1,1,3'd7,8'hEE,1, 3'd0,0,0,3'd0,8'h00,0);
    add(0,0,0,3'd0,8'h00,1, 3'd0,0,0,3'd0,8'h00,0);
    add(0,1,1,3'd4,8'h31,0, 3'd1,1,1,3'd4,8'h31,0);
    add(0,0,0,3'd0,8'h00,1, 3'd0,0,0,3'd0,8'h00,0);

    drive(0,0,0,3'd0,8'h00,0);
    rst_n = 1'b0;
    #12;
    check_all(-1, 3'd0, 0, 0, 3'd0, 8'h00, 0);
    rst_n = 1'b1;
    step_clk();

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].dir, vecs[i].sh, vecs[i].data, vecs[i].ordy);
      step_clk();
      check_all(i, vecs[i].e_cnt, vecs[i].e_val, vecs[i].e_dir, vecs[i].e_sh,
                vecs[i].e_data, vecs[i].e_full);
    end

    // Streaming: push and pop every cycle through two pointer wraps.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      d = 8'h10 + 8'(i);
      drive(0, 1, d[0], d[2:0], d, 1);
      step_clk();
      check_all(100 + i, 3'd1, 1, d[0], d[2:0], d, 0);
    end
    drive(0,0,0,3'd0,8'h00,1);
    step_clk();
    check_all(110, 3'd0, 0, 0, 3'd0, 8'h00, 0);

    // Asynchronous reset between edges with two entries held.
    drive(0,1,1,3'd6,8'h41,0);
    step_clk();
    drive(0,1,0,3'd7,8'h42,0);
    step_clk();
    check_all(200, 3'd2, 1, 1, 3'd6, 8'h41, 0);
    drive(0,0,0,3'd0,8'h00,0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all(201, 3'd0, 0, 0, 3'd0, 8'h00, 0);
    #3;
    rst_n = 1'b1;
    step_clk();
    drive(0,1,0,3'd3,8'h5A,0);
    step_clk();
    check_all(202, 3'd1, 1, 0, 3'd3, 8'h5A, 0);
    drive(0,0,0,3'd0,8'h00,1);
    step_clk();
    check_all(203, 3'd0, 0, 0, 3'd0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rotator_cmd_fifo.md
Name: rotator_cmd_fifo

Overview:
Buffers rotate commands {direction, shift amount, data} ahead of the combinational rotator. Decouples the command producer from the rotator/consumer timing with a valid/ready interface on both sides. Outputs connect straight to the rotator's Direction/SHAMT/data_in inputs. The occupancy and status outputs are used for producer throttling.

Parameters:
WIDTH, 8, data width of each rotate command; power of two, minimum 2.
DEPTH, 4, number of command entries; power of two, minimum 2.
SHW, $clog2(WIDTH), shift-amount width (derived, not overridable).
CW, $clog2(DEPTH)+1, occupancy count width (derived).

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of all stored commands.
in_valid  in  1  producer has a command.
in_ready  out  1  FIFO can accept; equals !full.
in_dir  in  1  1 = rotate left, 0 = rotate right.
in_shamt  in  SHW  rotate amount.
in_data  in  WIDTH  data to rotate.
out_valid  out  1  head command available; equals !empty.
out_ready  in  1  rotator/consumer takes the head this cycle.
rot_dir  out  1  head direction; feeds rotator Direction.
rot_shamt  out  SHW  head shift amount; feeds rotator SHAMT.
rot_data  out  WIDTH  head data; feeds rotator data_in.
count  out  CW  number of stored commands, 0..DEPTH.
full  out  1  count == DEPTH.
empty  out  1  count == 0.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: pointers 0, count 0, empty 1, full 0, in_ready 1, out_valid 0. Storage contents are not reset. rot_* are forced to 0 while empty.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Each is evaluated independently at the rising edge.
- Storage: DEPTH-entry register array of {dir, shamt, data}, 1+SHW+WIDTH bits wide.
- Pointers: wr_ptr and rd_ptr are CW bits wide; the MSB is a wrap bit.
  - full when the low bits are equal and the MSBs differ.
  - empty when the pointers are fully equal.
- Head presentation: first-word-fall-through. rot_* = mem[rd_ptr low bits], gated to 0 when empty.
- Latency: a push into an empty FIFO at edge N gives out_valid = 1 and the pushed values on rot_* immediately after edge N, with one cycle of latency and no bubble.
- Simultaneous push and pop when 0 < count < DEPTH: both occur and count is unchanged.
- When full: in_ready = 0, so a same-cycle pop does not enable a push. Count drops to DEPTH-1 and in_ready rises the next cycle.
- When empty: out_valid = 0, so no pop occurs and out_ready is ignored.
- Wrap-around: the low pointer bits wrap modulo DEPTH and the wrap bit toggles. Ordering is strictly first-in, first-out across the wrap.
- flush = 1 at an edge:
  - wr_ptr, rd_ptr and count go to 0.
  - flush overrides any same-cycle push or pop; the pushed command is discarded.
  - The FIFO is empty after the edge.
- Reset asserted mid-operation: all outputs take their reset values immediately, without waiting for an edge. In-flight commands are lost.
- count is registered and updated as +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH or goes below 0.
- in_shamt is stored unmodified, because its width already matches the rotator's SHAMT.
- No combinational path exists from in_* to out_* or from out_ready to in_ready.

Decomposition:
- Shared package rot_pkg holds:
  - the command struct typedef rot_cmd_t {dir, shamt[SHW-1:0], data[WIDTH-1:0]};
  - the constants ROT_LEFT = 1'b1 and ROT_RIGHT = 1'b0;
  - a function cmd_bits(WIDTH) returning 1+$clog2(WIDTH).
- One natural sub-module is rot_fifo_ptr: the pointer/count/full/empty logic, parameterized by DEPTH. The storage array and output gating stay in the top module.

Test Plan:
1. Reset with WIDTH=8, DEPTH=4 -> count=0, empty=1, full=0, in_ready=1, out_valid=0, rot_data=8'h00.
2. Push {1,3'd2,8'hA5} into empty with out_ready=0 -> next cycle out_valid=1, rot_dir=1, rot_shamt=2, rot_data=8'hA5, count=1.
3. Push 8'h01..8'h04 with out_ready=0 -> full=1, in_ready=0, count=4. A fifth push of 8'h05 is dropped. Then pop 4 times -> data 01,02,03,04 in order, and empty=1.
4. Run back-to-back push and pop for 10 commands (8'h10..8'h19) with out_ready=1 -> count stays 1 after the first push, outputs appear in order across two pointer wraps, and no command is lost.
5. With count=3, assert flush together with in_valid=1 (8'hEE) and out_ready=1 -> after the edge count=0, empty=1, and 8'hEE never appears.
6. With count=2, assert rst_n=0 between clock edges -> count=0, out_valid=0, rot_* = 0 without waiting for an edge. After release, push 8'h5A -> it appears at the head.
